led_shift_latch: RTL

Parametrised serial-in/parallel-out LED data receiver: the next generation of the controller's single-width shift register. It shifts a serial bit stream into a WIDTH-bit register, MSB-first or LSB-first. It counts bits per frame and latches completed frames into a stable parallel output that drives the LED drivers, either automatically or on an explicit strobe. It provides a cascade output for daisy-chaining and flags short and overlong frames.

---
 rtl/led_shift_latch.sv | 90 +++++++++
 1 files changed

// File: rtl/led_shift_latch.sv
// Serial-in/parallel-out LED data receiver: shifts a bit stream into a WIDTH-bit
// register, counts bits per frame and latches completed frames onto q.
module led_shift_latch #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int LSB_FIRST  = 0,
  parameter int AUTO_LATCH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             en,
  input  logic             latch,
  output logic             out,
  output logic [WIDTH-1:0] shift_q,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done,
  output logic             partial,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             shift_s;
  logic             latch_ev_s;
  logic             ovf_set_s;
  logic [WIDTH-1:0] shift_n_s;
  logic [CNT_W-1:0] cnt_n_s;

  // Next shift value, next bit count and latch decision for this edge
  always_comb begin
    shift_s   = ~en;
    shift_n_s = shift_q;
    cnt_n_s   = bit_cnt;
    ovf_set_s = 1'b0;
    if (shift_s) begin
      if (LSB_FIRST != 0) begin
        shift_n_s = {data, shift_q[WIDTH-1:1]};
      end else begin
        shift_n_s = {shift_q[WIDTH-2:0], data};
      end
      // Strobe-only mode saturates the count so an overlong frame still reads as full
      if ((AUTO_LATCH == 0) && (bit_cnt == FULL_CNT)) begin
        cnt_n_s   = FULL_CNT;
        ovf_set_s = 1'b1;
      end else begin
        cnt_n_s   = bit_cnt + CNT_W'(1'b1);
        ovf_set_s = 1'b0;
      end
    end else begin
      shift_n_s = shift_q;
      cnt_n_s   = bit_cnt;
      ovf_set_s = 1'b0;
    end
    latch_ev_s = latch || ((AUTO_LATCH != 0) && shift_s && (bit_cnt == LAST_CNT));
  end

  // Shift register, frame latch and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q    <= '0;
      q          <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      partial    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      shift_q <= shift_n_s;
      if (latch_ev_s) begin
        q          <= shift_n_s;
        bit_cnt    <= '0;
        frame_done <= 1'b1;
        partial    <= (cnt_n_s != FULL_CNT);
        ovf        <= 1'b0;
      end else begin
        q          <= q;
        bit_cnt    <= cnt_n_s;
        frame_done <= 1'b0;
        partial    <= partial;
        ovf        <= ovf | ovf_set_s;
      end
    end
  end

  // Cascade bit is the one the next shift pushes out
  assign out = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WIDTH-1];

endmodule
